fact_mm_ctrl: RTL and testbench
===============================

Name: fact_mm_ctrl

Overview:
- Memory-mapped controller that sequences an iterative 32-bit factorial datapath on the SoC memory-mapped bus.
- The CPU writes the operand n and a GO command, polls STATUS, then reads RESULT.
- The block contains the FSM, the operand/count/accumulator registers and the register file decode.
- Sits beside data memory behind the system address decoder, on the same we_mm/wd_mm/rd_mm bus.

Parameters:
- WIDTH, 32, data/result width
- N_WIDTH, 4, operand width
- MAX_N, 12, largest n whose factorial fits in WIDTH bits; larger n raises error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- we  in  1  write strobe for the addressed register, qualified by sel
- sel  in  1  block select from the address decoder; reads and writes are ignored when 0
- a  in  2  word address: 0=N, 1=GO/BUSY, 2=STATUS, 3=RESULT
- wd  in  WIDTH  write data
- rd  out  WIDTH  read data, combinational from a
- busy  out  1  high while the FSM is not in IDLE
- done  out  1  sticky completion flag; same value as STATUS[0]

Behaviour:
- Reset (rst=0, async): state=IDLE; n_reg, cnt, acc, result_reg, done, err all 0; busy=0; rd follows a over the reset values.
- Register map, reads:
  - a=0: {0, n_reg}
  - a=1: {0, busy}
  - a=2: {0, err, done}
  - a=3: result_reg
- Register map, writes (we&sel):
  - a=0: n_reg<=wd[N_WIDTH-1:0], only when IDLE; ignored otherwise.
  - a=1 with wd[0]=1: GO, accepted only when IDLE; ignored otherwise.
  - a=2, a=3: read-only, writes ignored.
- GO accepted: clear done and err, move to CHECK.
- Same-cycle N write and GO: impossible (single address); the N write must precede GO by at least one cycle.
- FSM states and transitions:
  - IDLE: wait for GO.
  - CHECK: if n_reg>MAX_N then err<=1, acc<=0, go to DONE. Else acc<=1, cnt<=n_reg, go to MULT.
  - MULT: if cnt<=1, go to DONE. Else acc<=acc*cnt (truncated to WIDTH), cnt<=cnt-1, stay in MULT.
  - DONE: result_reg<=acc, done<=1, go to IDLE. Exactly one cycle.
- Latency: edges from the GO-accept edge to done=1 are max(n,1)+2 for n≤MAX_N, and 2 for the error case.
- busy: high in CHECK, MULT and DONE; low in the cycle done is first seen high.
- Sticky state: done and err hold until the next accepted GO or reset. result_reg holds the last result and is never touched mid-computation.
- n=0 and n=1: result 1, err 0.
- Reset asserted mid-operation: immediately IDLE with all registers zeroed; no partial result becomes visible.
- Multiplier: single-cycle WIDTH×N_WIDTH product, no overflow possible within MAX_N.

Test Plan:
- Reset, write N=5, GO -> busy=1 next cycle; done=1 exactly 7 edges after GO; RESULT reads 120; STATUS reads 0x1; busy=0.
- N=0 then GO, and N=1 then GO -> each RESULT=1, done after 3 edges, err=0.
- N=12 then GO -> RESULT=479001600 (0x1C8CFC00), 14 edges.
- N=13 then GO -> STATUS=0x3 after 2 edges, RESULT=0.
- During an N=5 run: write N=3 and issue a second GO mid-MULT -> both ignored, RESULT=120, N reads 5.
- Then N=3, GO -> RESULT=6.
- Start N=7, drop rst for 1 cycle during MULT -> all reads 0, busy=0, done=0; a following N=4 GO gives RESULT=24.

Source files
------------

// File: rtl/fact_mm_ctrl.sv
// Memory-mapped iterative factorial engine: CPU writes N, issues GO, polls STATUS, reads RESULT.
// One multiply per cycle; done/err stay set until the next accepted GO.
module fact_mm_ctrl #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4,
  parameter int MAX_N   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               sel,
  input  logic [1:0]         a,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MULT, S_DONE} state_t;

  localparam logic [N_WIDTH-1:0] MAX_N_V = N_WIDTH'(MAX_N);
  localparam logic [N_WIDTH-1:0] ONE_V   = N_WIDTH'(1);

  state_t             state;
  logic [N_WIDTH-1:0] n_reg;
  logic [N_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   result_reg;
  logic               err;
  logic               n_wr;
  logic               go;

  assign n_wr = we && sel && (a == 2'd0);
  assign go   = we && sel && (a == 2'd1) && wd[0];

  // Only the low operand bits and the GO bit of the write data are meaningful.
  logic unused_wd;
  assign unused_wd = ^wd[WIDTH-1:N_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      n_reg      <= '0;
      cnt        <= '0;
      acc        <= '0;
      result_reg <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (n_wr) n_reg <= wd[N_WIDTH-1:0];
          if (go) begin
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (n_reg > MAX_N_V) begin
            err   <= 1'b1;
            acc   <= '0;
            state <= S_DONE;
          end else begin
            acc   <= WIDTH'(1);
            cnt   <= n_reg;
            state <= S_MULT;
          end
        end
        S_MULT: begin
          if (cnt <= ONE_V) begin
            state <= S_DONE;
          end else begin
            // cnt is zero-extended, so only a WIDTH x N_WIDTH product is really built
            acc <= acc * {{(WIDTH-N_WIDTH){1'b0}}, cnt};
            cnt <= cnt - ONE_V;
          end
        end
        S_DONE: begin
          result_reg <= acc;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (a)
      2'd0:    rd = {{(WIDTH-N_WIDTH){1'b0}}, n_reg};
      2'd1:    rd = {{(WIDTH-1){1'b0}}, busy};
      2'd2:    rd = {{(WIDTH-2){1'b0}}, err, done};
      default: rd = result_reg;
    endcase
  end

endmodule

// File: tb/tb_fact_mm_ctrl.sv
// Directed bench for fact_mm_ctrl: expected results queued at GO, checked when done rises.
module tb_fact_mm_ctrl;
  localparam int WIDTH   = 32;
  localparam int N_WIDTH = 4;
  localparam int MAX_N   = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             we  = 1'b0;
  logic             sel = 1'b0;
  logic [1:0]       a   = 2'd0;
  logic [WIDTH-1:0] wd  = '0;
  logic [WIDTH-1:0] rd;
  logic             busy;
  logic             done;

  fact_mm_ctrl #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst(rst), .we(we), .sel(sel), .a(a), .wd(wd),
    .rd(rd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] result;
    logic [31:0] status;
    int          lat;
    logic [31:0] n;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   go_cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    logic [31:0] f;
    e.n = n;
    if (n > MAX_N) begin
      e.result = 32'd0;
      e.status = 32'd3;
      e.lat    = 2;
    end else begin
      f = 32'd1;
      for (int i = 2; i <= n; i++) f = f * i;
      e.result = f;
      e.status = 32'd1;
      e.lat    = ((n < 1) ? 1 : n) + 2;
    end
    return e;
  endfunction

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wd = '0;
  endtask

  task automatic rd_reg(input logic [1:0] addr, output logic [31:0] v);
    a = addr;
    #1;
    v = rd;
  endtask

  task automatic start(input int n, input bit track);
    wr(2'd0, n);
    wr(2'd1, 32'd1);
    go_cyc = cyc;
    check("busy_after_go", {31'd0, busy}, 32'd1);
    check("done_cleared_by_go", {31'd0, done}, 32'd0);
    if (track) sb.push_back(model(n));
  endtask

  task automatic wait_done(input string tag);
    int guard;
    exp_t e;
    logic [31:0] v;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done observed %b, required 1 within 200 cycles", tag, done);
    end
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_scoreboard: no expected entry queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, cyc - go_cyc, e.lat);
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      rd_reg(2'd2, v); check({tag, "_status"}, v, e.status);
      rd_reg(2'd3, v); check({tag, "_result"}, v, e.result);
      rd_reg(2'd0, v); check({tag, "_n_readback"}, v, e.n);
    end
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    #2;
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], v);
      check("reset_reg", v, 32'd0);
    end
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    start(5, 1'b1);  wait_done("n5");
    start(0, 1'b1);  wait_done("n0");
    start(1, 1'b1);  wait_done("n1");
    start(12, 1'b1); wait_done("n12");
    start(13, 1'b1); wait_done("n13");

    // N write and second GO while computing must be ignored; RESULT unchanged mid-run
    start(5, 1'b1);
    wr(2'd0, 32'd3);
    rd_reg(2'd3, v); check("result_held_midrun", v, 32'd0);
    wr(2'd1, 32'd1);
    wait_done("n5_interfered");

    start(3, 1'b1); wait_done("n3");

    // Reset during MULT
    start(7, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], v);
      check("midreset_reg", v, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    start(4, 1'b1); wait_done("n4_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
